// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: widths, opcodes, FSM states.
package ctrl_pkg;

    localparam int DW = 4;
    localparam int IW = 2 * DW;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MUL = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JNZ = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Sequential DW x DW shift-add multiplier: one partial product per cycle.
// `start` latches the operands and clears the product; `product` is the
// running sum including the current iteration, so it is final while `done`.
module mul_shift_add #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] product,
    output logic            done
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [DW-1:0]   a_q, b_q;
    logic [2*DW-1:0] prod_q, prod_d, addend;
    logic [CW-1:0]   cnt_q;
    logic            active_q;

    // Partial product for the current multiplier bit, added to the running sum.
    always_comb begin
        addend = '0;
        if (b_q[cnt_q])
            addend = {{DW{1'b0}}, a_q} << cnt_q;
        prod_d = prod_q + addend;
    end

    assign product = prod_d;
    assign done    = active_q && (cnt_q == CW'(DW - 1));

    // Operand latch on start, then one iteration per cycle until the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            a_q      <= a;
            b_q      <= b;
            prod_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 1'b1;
            if (done)
                active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: decodes the ROM word at the current counter value,
// executes it against a DW-bit accumulator and steers the counter through
// busy (hold) and jump_flag/jump_addr (load).
module ctrl_seq #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   pc_in,
    input  logic [2*DW-1:0] instr_in,
    output logic            busy,
    output logic            jump_flag,
    output logic [DW-1:0]   jump_addr,
    output logic [DW-1:0]   acc_out,
    output logic            zero,
    output logic            carry,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    output logic            halted,
    output logic [DW-1:0]   halt_addr
);
    import ctrl_pkg::*;

    state_e          state_q;
    logic [DW-1:0]   acc_q, out_data_q, halt_addr_q;
    logic            zero_q, carry_q, out_valid_q, halted_q;

    logic [DW-1:0]   op, k;
    logic [DW:0]     add_res, sub_res;
    logic [DW-1:0]   and_res, xor_res;
    logic            mul_start, mul_done;
    logic [2*DW-1:0] mul_prod;

    assign op = instr_in[2*DW-1:DW];
    assign k  = instr_in[DW-1:0];

    // ALU results; the extra top bit is carry-out for ADD and borrow for SUB.
    always_comb begin
        add_res = {1'b0, acc_q} + {1'b0, k};
        sub_res = {1'b0, acc_q} - {1'b0, k};
        and_res = acc_q & k;
        xor_res = acc_q ^ k;
    end

    assign mul_start = (state_q == S_IDLE) && (op == OP_MUL);

    mul_shift_add #(.DW(DW)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (acc_q),
        .b       (k),
        .product (mul_prod),
        .done    (mul_done)
    );

    // Counter controls are combinational so the counter sees them at the same
    // edge; branches use the flags committed before this cycle.
    always_comb begin
        busy      = 1'b0;
        jump_flag = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_IDLE: begin
                    busy = (op == OP_MUL) || (op == OP_HLT);
                    unique case (op)
                        OP_JMP:  jump_flag = 1'b1;
                        OP_JZ:   jump_flag = zero_q;
                        OP_JNZ:  jump_flag = !zero_q;
                        OP_JC:   jump_flag = carry_q;
                        default: jump_flag = 1'b0;
                    endcase
                end
                S_MUL:   busy = !mul_done;
                S_HALT:  busy = 1'b1;
                default: busy = 1'b0;
            endcase
        end
        jump_addr = jump_flag ? k : '0;
    end

    // Instruction execution FSM; a MUL commits only on its final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            halt_addr_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    unique case (op)
                        OP_LDI: begin
                            acc_q  <= k;
                            zero_q <= (k == '0);
                        end
                        OP_ADD: begin
                            acc_q   <= add_res[DW-1:0];
                            carry_q <= add_res[DW];
                            zero_q  <= (add_res[DW-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc_q   <= sub_res[DW-1:0];
                            carry_q <= sub_res[DW];
                            zero_q  <= (sub_res[DW-1:0] == '0);
                        end
                        OP_AND: begin
                            acc_q  <= and_res;
                            zero_q <= (and_res == '0);
                        end
                        OP_XOR: begin
                            acc_q  <= xor_res;
                            zero_q <= (xor_res == '0);
                        end
                        OP_MUL: state_q <= S_MUL;
                        OP_OUT: begin
                            out_data_q  <= acc_q;
                            out_valid_q <= 1'b1;
                        end
                        OP_HLT: begin
                            state_q     <= S_HALT;
                            halted_q    <= 1'b1;
                            halt_addr_q <= pc_in;
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    if (mul_done) begin
                        acc_q   <= mul_prod[DW-1:0];
                        carry_q <= |mul_prod[2*DW-1:DW];
                        zero_q  <= (mul_prod[DW-1:0] == '0);
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign halt_addr = halt_addr_q;

endmodule
